crc32: RTL and testbench

- Byte-serial Ethernet CRC-32 (IEEE 802.3) engine, one byte per clock when qualified.
- MAC TX instantiates it to generate the FCS. MAC RX instantiates it to check the FCS by residue detection.
- Exposes the raw (non-inverted) CRC register and a frame-good flag.

---
 rtl/crc32.sv | 78 +++++++
 tb/tb_crc32.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/crc32.sv
// ---------------------------------------------------------------------------
// crc32
//   Byte-serial Ethernet CRC-32 engine (IEEE 802.3, reflected form).
//   One data byte is absorbed per clock while the qualifier is high.
//   TX side: after the covered bytes, send ~crc least-significant byte first
//   as the FCS.
//   RX side: feed the covered bytes plus the received FCS. The register then
//   lands on the fixed residue when the frame is intact.
//
// Ports
//   clk  in   1   system clock, rising-edge active
//   rst  in   1   asynchronous active-high reset, loads INIT
//   dat  in   8   data byte, bit 0 is first on the wire
//   val  in   1   byte qualifier, dat absorbed only when high
//   ok   out  1   high while the register equals RESIDUE
//   crc  out  32  raw (non-inverted) CRC register
// ---------------------------------------------------------------------------
module crc32 #(
  parameter logic [31:0] INIT      = 32'hFFFFFFFF,
  parameter logic [31:0] POLY_REFL = 32'hEDB88320,
  parameter logic [31:0] RESIDUE   = 32'hDEBB20E3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  dat,
  input  logic        val,
  output logic        ok,
  output logic [31:0] crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] byteNext;

  // Eight serial LFSR steps unrolled into one XOR network. The reflected
  // form shifts right and consumes the byte LSB first, matching wire order.
  function automatic logic [31:0] byteUpdate(input logic [31:0] cIn,
                                             input logic [7:0]  b);
    logic [31:0] c;
    logic        fb;
    c = cIn;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = (c >> 1) ^ (fb ? POLY_REFL : 32'h0);
    end
    return c;
  endfunction

  // Candidate register value if the current byte were absorbed.
  always_comb begin
    byteNext = byteUpdate(crc_q, dat);
  end

  // Next-state select. The register holds when val is low, so an undriven
  // or unknown dat during idle cycles never reaches the register.
  always_comb begin
    crc_d = crc_q;
    if (val) begin
      crc_d = byteNext;
    end
  end

  // The CRC register. Reset wins over a simultaneous valid byte, which is
  // therefore dropped; there is no automatic re-init between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  // Outputs come straight from the register so a byte is visible one cycle
  // after it is sampled. ok is a level and stays high while idle.
  assign crc = crc_q;
  assign ok  = (crc_q == RESIDUE);

endmodule

// File: tb/tb_crc32.sv
// ---------------------------------------------------------------------------
// tb_crc32
//   Directed self-checking bench for crc32 using hand-computed reference
//   values: the CRC-32 check string "123456789", its FCS, the single byte
//   0x00, gaps in val, and asynchronous resets.
// ---------------------------------------------------------------------------
module tb_crc32;

  logic        clk;
  logic        rst;
  logic [7:0]  dat;
  logic        val;
  logic        ok;
  logic [31:0] crc;

  int errCount;
  int checkCount;

  logic [7:0] frameBuf [0:15];

  crc32 dut (
    .clk (clk),
    .rst (rst),
    .dat (dat),
    .val (val),
    .ok  (ok),
    .crc (crc)
  );

  // Free-running clock, 10 time-unit period with rising edges at 5, 15, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point. Every check is counted, and a mismatch is reported.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, observed, expected);
    end
  endtask

  // Hold reset across two clock edges and release it at a falling edge.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    val = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive frameBuf[0..len-1] one byte per cycle at falling edges. When
  // maxGap is nonzero, insert 0..maxGap idle cycles (val low, dat unknown)
  // before each byte. The task returns at the first falling edge after the
  // last byte has been sampled.
  task automatic applyStimulus(input int len, input int maxGap);
    int gap;
    for (int i = 0; i < len; i++) begin
      gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        val = 1'b0;
        dat = 8'hxx;
      end
      @(negedge clk);
      val = 1'b1;
      dat = frameBuf[i];
    end
    @(negedge clk);
    val = 1'b0;
    dat = 8'hxx;
  endtask

  // Fill frameBuf[0..8] with ASCII "123456789".
  task automatic loadCheckString();
    for (int i = 0; i < 9; i++) begin
      frameBuf[i] = 8'h31 + 8'(i);
    end
  endtask

  // Append the FCS of "123456789" (~0x340BC6D9 = 0xCBF43926, LSB first).
  task automatic loadCheckFcs();
    frameBuf[9]  = 8'h26;
    frameBuf[10] = 8'h39;
    frameBuf[11] = 8'hF4;
    frameBuf[12] = 8'hCB;
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    rst = 1'b1;
    val = 1'b0;
    dat = 8'h00;

    // Reset values, both during reset and for 10 idle cycles after release.
    #2;
    checkOutput("crcInReset", crc, 32'hFFFFFFFF);
    checkOutput("okInReset", {31'b0, ok}, 32'h0);
    doReset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("crcIdle", crc, 32'hFFFFFFFF);
      checkOutput("okIdle", {31'b0, ok}, 32'h0);
    end

    // Single byte '1': CRC32("1") = 0x83DCEFB7, raw = 0x7C231048.
    frameBuf[0] = 8'h31;
    applyStimulus(1, 0);
    checkOutput("crcOneByte", crc, 32'h7C231048);

    // Check string without gaps.
    doReset();
    loadCheckString();
    applyStimulus(9, 0);
    checkOutput("crcCheckStr", crc, 32'h340BC6D9);
    checkOutput("okCheckStr", {31'b0, ok}, 32'h0);

    // Check string plus FCS must land on the residue, and ok must stay high while idle.
    doReset();
    loadCheckString();
    loadCheckFcs();
    applyStimulus(13, 0);
    checkOutput("crcResidue", crc, 32'hDEBB20E3);
    checkOutput("okResidue", {31'b0, ok}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("okHold", {31'b0, ok}, 32'h1);
    end
    checkOutput("crcHold", crc, 32'hDEBB20E3);

    // The same streams with random idle gaps must give the same results.
    doReset();
    applyStimulus(9, 5);
    checkOutput("crcGapStr", crc, 32'h340BC6D9);
    doReset();
    applyStimulus(13, 5);
    checkOutput("crcGapRes", crc, 32'hDEBB20E3);
    checkOutput("okGapRes", {31'b0, ok}, 32'h1);

    // Single byte 0x00: CRC32 = 0xD202EF8D, raw = 0x2DFD1072.
    doReset();
    frameBuf[0] = 8'h00;
    applyStimulus(1, 0);
    checkOutput("crcZero", crc, 32'h2DFD1072);

    // 0x00 with its correct FCS (8D EF 02 D2) must be accepted.
    doReset();
    frameBuf[1] = 8'h8D;
    frameBuf[2] = 8'hEF;
    frameBuf[3] = 8'h02;
    frameBuf[4] = 8'hD2;
    applyStimulus(5, 0);
    checkOutput("okZeroFcs", {31'b0, ok}, 32'h1);

    // The same frame with one FCS bit flipped must be rejected.
    doReset();
    frameBuf[1] = 8'h8C;
    applyStimulus(5, 0);
    checkOutput("okBadFcs", {31'b0, ok}, 32'h0);
    checkOutput("crcBadFcsNotRes", {31'b0, crc == 32'hDEBB20E3}, 32'h0);

    // Asynchronous reset between clock edges during a stream.
    doReset();
    loadCheckString();
    applyStimulus(4, 0);
    checkOutput("crcPartial", {31'b0, crc == 32'hFFFFFFFF}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("crcAsyncRst", crc, 32'hFFFFFFFF);
    checkOutput("okAsyncRst", {31'b0, ok}, 32'h0);
    rst = 1'b0;
    applyStimulus(9, 0);
    checkOutput("crcAfterAsync", crc, 32'h340BC6D9);

    // rst and val high together: the byte is discarded.
    @(negedge clk);
    rst = 1'b1;
    val = 1'b1;
    dat = 8'h31;
    @(negedge clk);
    checkOutput("crcRstWins", crc, 32'hFFFFFFFF);
    val = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("crcPostRst", crc, 32'hFFFFFFFF);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
